// File: rtl/peek_fifo_stream_rd.sv
// Read-side controller for a peek FIFO: drains it into a two-entry registered
// output buffer and exposes a one-element lookahead to the downstream consumer.
//   state | meaning
//   EMPTY | no element buffered, out_val low
//   ONE   | r_head valid
//   TWO   | r_head and r_sec valid
module peek_fifo_stream_rd #(
  parameter int DATA_W = 32,
  parameter int ELS    = 4,
  parameter int ELS_W  = $clog2(ELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fifo_rd_req,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic [DATA_W-1:0] fifo_rd_data_next,
  input  logic [ELS_W:0]    fifo_num_els,
  output logic              fifo_clear,
  input  logic              flush,
  output logic              out_val,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_rdy,
  output logic              out_next_val,
  output logic [DATA_W-1:0] out_next_data,
  output logic [ELS_W+1:0]  total_els
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } cnt_e;

  cnt_e              r_cnt;
  cnt_e              w_cnt_nxt;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_sec;
  logic [DATA_W-1:0] w_head_nxt;
  logic [DATA_W-1:0] w_sec_nxt;
  logic              w_acc;
  logic              w_fifo_has;
  logic              w_pop;
  logic [1:0]        w_cnt_bits;

  assign w_acc      = (r_cnt != EMPTY) & out_rdy;
  assign w_fifo_has = (fifo_num_els != '0);
  // Gating with rst_n keeps the FIFO from being popped while we are held in reset.
  assign w_pop      = rst_n & ~flush & w_fifo_has & ((r_cnt != TWO) | w_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= EMPTY;
      r_head <= '0;
      r_sec  <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_head <= w_head_nxt;
      r_sec  <= w_sec_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_head_nxt = r_head;
    w_sec_nxt  = r_sec;
    if (flush) begin
      w_cnt_nxt = EMPTY;
    end else begin
      case (r_cnt)
        EMPTY: begin
          if (w_pop) begin
            w_head_nxt = fifo_rd_data;
            w_cnt_nxt  = ONE;
          end
        end
        ONE: begin
          if (w_pop && !w_acc) begin
            w_sec_nxt = fifo_rd_data;
            w_cnt_nxt = TWO;
          end else if (w_pop && w_acc) begin
            w_head_nxt = fifo_rd_data;
          end else if (w_acc) begin
            w_cnt_nxt = EMPTY;
          end
        end
        TWO: begin
          if (w_acc) begin
            w_head_nxt = r_sec;
            if (w_pop) begin
              w_sec_nxt = fifo_rd_data;
            end else begin
              w_cnt_nxt = ONE;
            end
          end
        end
        default: w_cnt_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_next_val  = 1'b0;
    out_next_data = r_sec;
    case (r_cnt)
      TWO: begin
        out_next_val  = 1'b1;
        out_next_data = r_sec;
      end
      ONE: begin
        if (w_fifo_has) begin
          out_next_val  = 1'b1;
          out_next_data = fifo_rd_data;
        end
      end
      EMPTY: out_next_data = fifo_rd_data_next;
      default: begin
        out_next_val  = 1'b0;
        out_next_data = r_sec;
      end
    endcase
  end

  assign w_cnt_bits  = r_cnt;
  assign fifo_rd_req = w_pop;
  assign fifo_clear  = flush;
  assign out_val     = (r_cnt != EMPTY);
  assign out_data    = r_head;
  assign total_els   = (ELS_W+2)'(w_cnt_bits) + (ELS_W+2)'(fifo_num_els);

endmodule

// File: tb/tb_peek_fifo_stream_rd.sv
// Bench for peek_fifo_stream_rd: a queue-based FIFO model feeds the DUT and a
// scoreboard of written elements is checked against every accepted output.
module tb_peek_fifo_stream_rd;
  localparam int DW = 32;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_rd_req;
  logic [DW-1:0] fifo_rd_data = '0;
  logic [DW-1:0] fifo_rd_data_next = '0;
  logic [EW:0]   fifo_num_els = '0;
  logic          fifo_clear;
  logic          flush = 1'b0;
  logic          out_val;
  logic [DW-1:0] out_data;
  logic          out_rdy = 1'b0;
  logic          out_next_val;
  logic [DW-1:0] out_next_data;
  logic [EW+1:0] total_els;

  always #5 clk = ~clk;

  peek_fifo_stream_rd #(.DATA_W(DW), .ELS(4), .ELS_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_rd_req(fifo_rd_req), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_data_next(fifo_rd_data_next), .fifo_num_els(fifo_num_els),
    .fifo_clear(fifo_clear), .flush(flush),
    .out_val(out_val), .out_data(out_data), .out_rdy(out_rdy),
    .out_next_val(out_next_val), .out_next_data(out_next_data),
    .total_els(total_els)
  );

  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int nxt = 0;
  logic last_rd;
  logic last_acc;

  typedef struct {
    logic rdy;
    logic fl;
    int   npush;
    logic erd;
    logic eval;
    logic env;
    int   etot;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic upd();
    fifo_rd_data      = (fq.size() > 0) ? fq[0] : '0;
    fifo_rd_data_next = (fq.size() > 1) ? fq[1] : '0;
    fifo_num_els      = (EW+1)'(fq.size());
  endtask

  task automatic push();
    logic [DW-1:0] d;
    d = 32'hD000_0000 + DW'(nxt);
    nxt++;
    fq.push_back(d);
    sb.push_back(d);
    upd();
  endtask

  // One clock cycle: check against the model before the edge, advance the model after.
  task automatic step();
    int   b;
    logic erd;
    logic eacc;
    #1;
    b    = sb.size() - fq.size();
    erd  = !flush && (fq.size() != 0) && (b < 2 || out_rdy);
    eacc = (b != 0) && out_rdy;
    chk("rd_req", fifo_rd_req, erd);
    chk("out_val", out_val, b != 0);
    chk("total_els", total_els, sb.size());
    chk("fifo_clear", fifo_clear, flush);
    last_rd  = fifo_rd_req;
    last_acc = eacc;
    if (eacc) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL stream_data: got %0h expected none", out_data);
      end else begin
        chk("stream_data", out_data, sb[0]);
      end
    end
    @(posedge clk);
    #1;
    if (flush) begin
      fq.delete();
      sb.delete();
    end else begin
      if (eacc) void'(sb.pop_front());
      if (erd) void'(fq.pop_front());
    end
    upd();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops;
    int accs;
    int first_rd;
    int first_acc;
    logic prev_stall;
    logic [DW-1:0] prev_d;
    logic [DW-1:0] a_val;
    logic [DW-1:0] b_val;

    //            rdy   fl    np erd   eval  env   tot
    tbl[0]  = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 3};
    tbl[2]  = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1, 3};
    tbl[3]  = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 3};
    tbl[4]  = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 3};
    tbl[5]  = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 2};
    tbl[6]  = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1};
    tbl[7]  = '{1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b1, 3};
    tbl[8]  = '{1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 3};
    tbl[9]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[10] = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1};
    tbl[11] = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1};
    tbl[12] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};

    #3;
    chk("rst_out_val", out_val, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_next_val", out_next_val, 0);
    chk("rst_rd_req", fifo_rd_req, 0);
    chk("rst_clear", fifo_clear, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven cycle vectors
    for (int i = 0; i < 13; i++) begin
      out_rdy = tbl[i].rdy;
      flush   = tbl[i].fl;
      for (int k = 0; k < tbl[i].npush; k++) push();
      #1;
      chk($sformatf("tbl%0d_rd", i), fifo_rd_req, tbl[i].erd);
      chk($sformatf("tbl%0d_val", i), out_val, tbl[i].eval);
      chk($sformatf("tbl%0d_nval", i), out_next_val, tbl[i].env);
      chk($sformatf("tbl%0d_tot", i), total_els, tbl[i].etot);
      chk($sformatf("tbl%0d_clr", i), fifo_clear, tbl[i].fl);
      step();
    end
    flush = 1'b0;

    // A,B,C streamed with out_rdy high: 3 pops, first output one cycle after first pop
    out_rdy = 1'b1;
    repeat (3) push();
    pops = 0; accs = 0; first_rd = -1; first_acc = -1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (last_rd) begin pops++; if (first_rd < 0) first_rd = i; end
      if (last_acc) begin accs++; if (first_acc < 0) first_acc = i; end
    end
    chk("abc_pops", pops, 3);
    chk("abc_accs", accs, 3);
    chk("abc_latency", first_acc - first_rd, 1);

    // Four preloaded with out_rdy low: exactly two pops, then back-to-back drain
    out_rdy = 1'b0;
    a_val = 32'hD000_0000 + DW'(nxt);
    b_val = a_val + 1;
    repeat (4) push();
    pops = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (last_rd) pops++;
    end
    chk("pre4_pops", pops, 2);
    chk("pre4_head", out_data, a_val);
    chk("pre4_next", out_next_data, b_val);
    chk("pre4_nval", out_next_val, 1);
    out_rdy = 1'b1;
    accs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (last_acc) accs++;
    end
    chk("pre4_accs", accs, 4);

    // Lookahead from ONE into the FIFO, then from r_sec
    out_rdy = 1'b0;
    a_val = 32'hD000_0000 + DW'(nxt);
    push();
    step();
    b_val = 32'hD000_0000 + DW'(nxt);
    push();
    #1;
    chk("look1_val", out_next_val, 1);
    chk("look1_data", out_next_data, b_val);
    chk("look1_head", out_data, a_val);
    step();
    #1;
    chk("look2_val", out_next_val, 1);
    chk("look2_data", out_next_data, b_val);
    out_rdy = 1'b1;
    repeat (3) step();

    // out_rdy toggling with continuous refill
    prev_stall = 1'b0;
    prev_d = '0;
    for (int i = 0; i < 12; i++) begin
      if (fq.size() < 2) push();
      out_rdy = (i % 2 == 0);
      #1;
      if (prev_stall) chk("stall_hold", out_data, prev_d);
      prev_stall = out_val && !out_rdy;
      prev_d = out_data;
      step();
    end
    out_rdy = 1'b1;
    repeat (6) step();
    chk("drain_empty", sb.size(), 0);

    // Flush in TWO with two elements still in the FIFO
    out_rdy = 1'b0;
    repeat (4) push();
    repeat (3) step();
    flush = 1'b1;
    #1;
    chk("flush_clear", fifo_clear, 1);
    chk("flush_rd", fifo_rd_req, 0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_val", out_val, 0);
    chk("flush_tot", total_els, 0);
    step();

    // Asynchronous reset mid-stream
    out_rdy = 1'b1;
    repeat (4) push();
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_val", out_val, 0);
    chk("arst_rd", fifo_rd_req, 0);
    chk("arst_data", out_data, 0);
    fq.delete();
    sb.delete();
    upd();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_val = 32'hD000_0000 + DW'(nxt);
    push();
    step();
    #1;
    chk("post_rst_val", out_val, 1);
    chk("post_rst_data", out_data, a_val);
    repeat (2) step();
    chk("final_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/peek_fifo_stream_rd.md
Name: peek_fifo_stream_rd

Overview:
Read-side controller for a small peek FIFO. It drains the FIFO through its rd_req / rd_data / rd_data_next / num_els / clear_fifo interface and presents a registered valid/ready output stream. A two-entry output buffer decouples the FIFO's combinational read data from downstream timing while sustaining one element per cycle. A one-element lookahead is exposed downstream, and a flush clears both the buffer and the FIFO.

Parameters:
DATA_W, 32, element width in bits.
ELS, 4, depth of the attached FIFO.
ELS_W, $clog2(ELS), FIFO pointer width.

Ports:
clk  input  1  clock.
rst_n  input  1  reset, asynchronous, active-low.
fifo_rd_req  output  1  pop one FIFO element this cycle.
fifo_rd_data  input  DATA_W  FIFO head element.
fifo_rd_data_next  input  DATA_W  FIFO element after the head.
fifo_num_els  input  ELS_W+1  FIFO occupancy.
fifo_clear  output  1  clear request to the FIFO.
flush  input  1  drop all buffered and queued data.
out_val  output  1  out_data valid.
out_data  output  DATA_W  head of stream, registered.
out_rdy  input  1  downstream accept.
out_next_val  output  1  out_next_data valid.
out_next_data  output  DATA_W  element following out_data.
total_els  output  ELS_W+2  buffered count plus fifo_num_els.

Behaviour:
- Reset and clock: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset state: cnt=0, head_r=0, sec_r=0.
- Resulting outputs in reset: out_val=0, out_data=0, out_next_val=0, fifo_rd_req=0, fifo_clear=0.
- State: cnt in {EMPTY=0, ONE=1, TWO=2}, holding registers head_r and sec_r. out_val = (cnt!=0). out_data = head_r.
- Accept: acc = out_val & out_rdy.
- Pop: pop = !flush & (fifo_num_els!=0) & (cnt<2 | acc). fifo_rd_req = pop.
  - Never pop an empty FIFO.
  - Pop in TWO only when an accept frees a slot in the same cycle.
- Transitions and data updates, registered at posedge, next cnt = cnt + pop - acc:
  - EMPTY, pop: head_r <= fifo_rd_data, go to ONE. acc is impossible in EMPTY.
  - ONE, pop & !acc: sec_r <= fifo_rd_data, go to TWO.
  - ONE, pop & acc: head_r <= fifo_rd_data, stay in ONE.
  - ONE, acc only: go to EMPTY.
  - TWO, acc & pop: head_r <= sec_r, sec_r <= fifo_rd_data, stay in TWO.
  - TWO, acc only: head_r <= sec_r, go to ONE.
  - TWO, no acc: hold everything. out_data stays stable while out_val & !out_rdy.
- Latency: a FIFO element popped in cycle N appears on out_data at cycle N+1 when the buffer was EMPTY. Sustained throughput is 1 element/cycle with out_rdy held high.
- Lookahead (combinational):
  - TWO: out_next_val=1, out_next_data=sec_r.
  - ONE and fifo_num_els>=1: out_next_val=1, out_next_data=fifo_rd_data.
  - EMPTY: out_next_val=0 and out_next_data=fifo_rd_data_next. This is don't-care for consumers but is driven deterministically.
  - Otherwise: out_next_val=0, out_next_data=sec_r.
- total_els = cnt + fifo_num_els, zero-extended, combinational. Maximum value is ELS+2.
- Flush:
  - fifo_clear = flush, combinational, same cycle.
  - fifo_rd_req=0 while flush is high.
  - Next cycle cnt=0 and out_val=0. head_r and sec_r keep stale data.
  - An acc coinciding with flush still completes downstream, but the buffer is emptied regardless.
  - Flush has priority over pop and acc.
- Reset mid-stream: outputs drop immediately and asynchronously. The FIFO is reset independently by its owner.
- out_rdy may be asserted while out_val=0. This has no effect.

Test Plan:
- Reset, then ELS=4 FIFO preloaded with A,B,C, out_rdy=1 -> fifo_rd_req high for 3 cycles. out_data = A,B,C on consecutive cycles starting 1 cycle after the first pop. out_val then falls.
- Preload FIFO with 4 elements, out_rdy=0 -> exactly 2 pops, cnt=TWO, total_els=4 throughout. out_data=A, out_next_data=B, fifo_num_els=2. Raising out_rdy then streams A,B,C,D back-to-back.
- cnt=ONE (head=A), FIFO holds B, out_rdy=0 -> out_next_val=1, out_next_data=B. Next cycle sec_r=B and the lookahead still reads B.
- TWO with out_rdy toggling 1,0,1 and FIFO continuously refilled -> no element lost or duplicated, pop only in cycles with acc, out_data stable during the stall.
- flush asserted in TWO with FIFO holding 2 elements -> fifo_clear=1 the same cycle, fifo_rd_req=0, next cycle out_val=0, total_els=0.
- rst_n pulsed low asynchronously mid-stream, between clock edges -> out_val and fifo_rd_req go to 0 immediately. After release, a new element is delivered with 1-cycle latency.
